// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: selector encoding,
// selector width and skid-buffer occupancy states.
package imm_pkg;

   localparam int IMM_SRC_W = 3;

   typedef enum logic [IMM_SRC_W-1:0] {
      SRC_I   = 3'b000,
      SRC_S   = 3'b001,
      SRC_U   = 3'b010,
      SRC_Z   = 3'b011,
      SRC_SH  = 3'b100,
      SRC_B   = 3'b101,
      SRC_J   = 3'b110,
      SRC_ERR = 3'b111
   } imm_src_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for one instruction word, extended to XLEN.
// Opcode bits [6:0] never contribute, so only [31:7] is taken.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]          inst,
   input  logic [IMM_SRC_W-1:0] imm_src,
   output logic [XLEN-1:0]      imm_ext,
   output logic                 imm_err
);

   logic signed [11:0] imm_i;
   logic signed [11:0] imm_s;
   logic signed [12:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [20:0] imm_j;
   logic        [4:0]  zimm;
   logic        [5:0]  shamt;

   assign imm_i = inst[31:20];
   assign imm_s = {inst[31:25], inst[11:7]};
   assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign zimm  = inst[19:15];
   // RV64 shift amounts carry a sixth bit; RV32 keeps bit 25 out of the amount
   assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

   always_comb begin
      imm_ext = '0;
      imm_err = 1'b0;
      case (imm_src_e'(imm_src))
         SRC_I:   imm_ext = XLEN'(imm_i);
         SRC_S:   imm_ext = XLEN'(imm_s);
         SRC_B:   imm_ext = XLEN'(imm_b);
         SRC_U:   imm_ext = XLEN'(imm_u);
         SRC_J:   imm_ext = XLEN'(imm_j);
         SRC_Z:   imm_ext = XLEN'(zimm);
         SRC_SH:  imm_ext = XLEN'(shamt);
         SRC_ERR: imm_err = 1'b1;
         default: imm_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode feeding a 2-entry
// skid buffer with registered in_ready, flush and async active-low reset.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          inst,
   input  logic [IMM_SRC_W-1:0] imm_src,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      imm_ext,
   output logic                 imm_err
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic            err;
   } imm_entry_t;

   imm_entry_t  dec_p0;
   imm_entry_t  head_p1;
   imm_entry_t  tail_p1;
   skid_state_e state_p1;
   skid_state_e state_nxt;
   logic        rdy_p1;
   logic        acc;
   logic        dlv;
   logic        load_head;
   logic        shift_head;
   logic        load_tail;
   logic        unused_opcode;

   assign unused_opcode = ^inst[6:0];

   // stage p0: decode the beat presented on the input
   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst    (inst[31:7]),
      .imm_src (imm_src),
      .imm_ext (dec_p0.imm),
      .imm_err (dec_p0.err)
   );

   assign acc = in_valid && rdy_p1 && !flush;
   assign dlv = out_valid && out_ready && !flush;

   always_comb begin
      state_nxt  = state_p1;
      load_head  = 1'b0;
      shift_head = 1'b0;
      load_tail  = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_p1)
            ST_EMPTY: begin
               if (acc) begin
                  state_nxt = ST_ONE;
                  load_head = 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && dlv) begin
                  load_head = 1'b1;
               end else if (acc) begin
                  state_nxt = ST_TWO;
                  load_tail = 1'b1;
               end else if (dlv) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (dlv) begin
                  state_nxt  = ST_ONE;
                  shift_head = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // stage p1: occupancy state and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= ST_EMPTY;
         rdy_p1   <= 1'b1;
      end else begin
         state_p1 <= state_nxt;
         rdy_p1   <= (state_nxt != ST_TWO);
      end
   end

   // head drives the outputs directly, so it must come out of reset as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_p1 <= '0;
      end else if (load_head) begin
         head_p1 <= dec_p0;
      end else if (shift_head) begin
         head_p1 <= tail_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (load_tail) begin
         tail_p1 <= dec_p0;
      end
   end

   assign in_ready  = rdy_p1;
   assign out_valid = (state_p1 != ST_EMPTY);
   assign imm_ext   = head_p1.imm;
   assign imm_err   = head_p1.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus;
// table vectors, handshake sequences and a scoreboard model.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] inst = '0;
   logic [2:0]  imm_src = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, imm_err;
   logic [31:0] imm_ext;
   logic        rdy64, vld64, err64;
   logic [63:0] ext64;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .imm_src(imm_src), .out_valid(out_valid), .out_ready(out_ready),
      .imm_ext(imm_ext), .imm_err(imm_err)
   );

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .inst(inst), .imm_src(imm_src), .out_valid(vld64), .out_ready(out_ready),
      .imm_ext(ext64), .imm_err(err64)
   );

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  src;
      logic [63:0] e32;
      logic [63:0] e64;
      logic        err;
   } vec_t;

   typedef struct {
      logic [63:0] e32;
      logic [63:0] e64;
      logic        err;
   } exp_t;

   vec_t vecs[12];
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference built from arithmetic shifts of the sign-extended word
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src,
                                           input bit x64);
      longint s;
      longint v;
      s = longint'($signed(w));
      case (src)
         3'b000: v = s >>> 20;
         3'b001: v = ((s >>> 25) <<< 5) | longint'(w[11:7]);
         3'b101: v = ((s >>> 31) <<< 12) | (longint'(w[7]) <<< 11)
                     | (longint'(w[30:25]) <<< 5) | (longint'(w[11:8]) <<< 1);
         3'b010: v = (s >>> 12) <<< 12;
         3'b110: v = ((s >>> 31) <<< 20) | (longint'(w[19:12]) <<< 12)
                     | (longint'(w[20]) <<< 11) | (longint'(w[30:21]) <<< 1);
         3'b011: v = longint'(w[19:15]);
         3'b100: v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
         default: v = 0;
      endcase
      return x64 ? v : {32'b0, v[31:0]};
   endfunction

   // drives beats until all are delivered; out_ready is low for the first 'stall' cycles
   task automatic stream(input int n, input int stall, input int max_cyc, input bit rnd,
                         output int cycles, output int ndel, output int nacc_stall);
      int          idx;
      logic [31:0] cur_inst;
      logic [2:0]  cur_src;
      bit          was_stalled;
      logic [63:0] prev_head;
      exp_t        e;
      idx = 0; cycles = 0; ndel = 0; nacc_stall = 0; was_stalled = 0; prev_head = '0;
      sb.delete();
      cur_inst = rnd ? $urandom : (32'(idx + 1) << 20) | 32'h13;
      cur_src  = rnd ? 3'($urandom_range(0, 7)) : 3'b000;
      while ((idx < n || sb.size() != 0) && cycles < max_cyc) begin
         in_valid  = (idx < n);
         inst      = cur_inst;
         imm_src   = cur_src;
         out_ready = (cycles >= stall);
         #2;
         if (was_stalled) chk("head_hold", {32'b0, imm_ext}, prev_head);
         if (cycles < stall) chk("in_ready_stall", {63'b0, in_ready}, {63'b0, nacc_stall < 2});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_delivery", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("deliver32", {32'b0, imm_ext}, e.e32);
               chk("deliver64", ext64, e.e64);
               chk("deliver_err", {63'b0, imm_err}, {63'b0, e.err});
            end
            ndel++;
         end
         if (in_valid && in_ready) begin
            e.e32 = ref_imm(cur_inst, cur_src, 1'b0);
            e.e64 = ref_imm(cur_inst, cur_src, 1'b1);
            e.err = (cur_src == 3'b111);
            sb.push_back(e);
            if (cycles < stall) nacc_stall++;
            idx++;
            cur_inst = rnd ? $urandom : (32'(idx + 1) << 20) | 32'h13;
            cur_src  = rnd ? 3'($urandom_range(0, 7)) : 3'b000;
         end
         was_stalled = out_valid && !out_ready;
         prev_head   = {32'b0, imm_ext};
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
      chk("stream_drained", 64'(sb.size() + (n - idx)), 64'd0);
   endtask

   task automatic beat(input logic [31:0] w, input logic [2:0] src);
      in_valid = 1'b1;
      inst     = w;
      imm_src  = src;
   endtask

   initial begin
      int cyc, ndel, nacc;

      vecs[0]  = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[1]  = '{32'h800000EF, 3'b110, 64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
      vecs[2]  = '{32'h12345037, 3'b010, 64'h12345000, 64'h0000000012345000, 1'b0};
      vecs[3]  = '{32'h800F8073, 3'b011, 64'h1F,       64'h1F,               1'b0};
      vecs[4]  = '{32'h83F01013, 3'b100, 64'h1F,       64'h3F,               1'b0};
      vecs[5]  = '{32'hFFFFFFFF, 3'b111, 64'h0,        64'h0,                1'b1};
      vecs[6]  = '{32'h00A12423, 3'b001, 64'h8,        64'h8,                1'b0};
      vecs[7]  = '{32'hFE000EE3, 3'b101, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[8]  = '{32'h7FF00013, 3'b000, 64'h7FF,      64'h7FF,              1'b0};
      vecs[9]  = '{32'h0080006F, 3'b110, 64'h8,        64'h8,                1'b0};
      vecs[10] = '{32'hFFFFF037, 3'b010, 64'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
      vecs[11] = '{32'h02001013, 3'b100, 64'h0,        64'h20,               1'b0};

      // asynchronous reset with no clock edge in between
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
      chk("rst_imm_ext",   {32'b0, imm_ext},   64'd0);
      chk("rst_imm_err",   {63'b0, imm_err},   64'd0);
      chk("rst_imm_ext64", ext64,              64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // table vectors at full rate, one cycle latency
      out_ready = 1'b1;
      beat(vecs[0].inst, vecs[0].src);
      #1 chk("pre_latency_valid", {63'b0, out_valid}, 64'd0);
      for (int i = 0; i < 12; i++) begin
         beat(vecs[i].inst, vecs[i].src);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
         chk($sformatf("vec%0d_ext32", i), {32'b0, imm_ext}, vecs[i].e32);
         chk($sformatf("vec%0d_ext64", i), ext64, vecs[i].e64);
         chk($sformatf("vec%0d_err", i), {62'b0, imm_err, err64}, {62'b0, vecs[i].err, vecs[i].err});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("table_drain_valid", {63'b0, out_valid}, 64'd0);

      // back-pressure: 5 beats, out_ready low for 4 cycles
      stream(5, 4, 60, 1'b0, cyc, ndel, nacc);
      chk("bp_accepts_while_stalled", 64'(nacc), 64'd2);
      chk("bp_deliveries", 64'(ndel), 64'd5);

      // full-rate random streaming
      stream(100, 0, 400, 1'b1, cyc, ndel, nacc);
      chk("stream_deliveries", 64'(ndel), 64'd100);
      chk("stream_cycles", 64'(cyc), 64'd101);

      // flush in TWO with a beat presented and out_ready low
      out_ready = 1'b0;
      beat(32'h00100013, 3'b000);
      @(posedge clk); #1;
      beat(32'h00200013, 3'b000);
      @(posedge clk); #1;
      chk("two_in_ready", {63'b0, in_ready}, 64'd0);
      chk("two_head", {32'b0, imm_ext}, 64'd1);
      beat(32'h00300013, 3'b000);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_two_valid", {63'b0, out_valid}, 64'd0);
      chk("flush_two_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("flush_no_ghost", {63'b0, out_valid}, 64'd0);
      end

      // flush in ONE while accept and deliver would both fire
      beat(32'h00400013, 3'b000);
      @(posedge clk); #1;
      beat(32'h00500013, 3'b000);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_one_valid", {63'b0, out_valid}, 64'd0);
      beat(32'h00600013, 3'b000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_flush_valid", {63'b0, out_valid}, 64'd1);
      chk("post_flush_ext", {32'b0, imm_ext}, 64'd6);
      @(posedge clk); #1;
      chk("post_flush_drain", {63'b0, out_valid}, 64'd0);

      // reset mid-operation in ONE with out_ready low
      out_ready = 1'b0;
      beat(32'h7FF00013, 3'b000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("one_before_rst", {32'b0, imm_ext}, 64'h7FF);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {62'b0, out_valid, vld64}, 64'd0);
      chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
      chk("mid_rst_ext", {32'b0, imm_ext}, 64'd0);
      chk("mid_rst_ext64", ext64, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      beat(32'h00A12423, 3'b001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("after_rst_valid", {63'b0, out_valid}, 64'd1);
      chk("after_rst_ext", {32'b0, imm_ext}, 64'd8);
      @(posedge clk); #1;
      chk("after_rst_drain", {63'b0, out_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined core's decode stage. It accepts a 32-bit instruction word plus an immediate-type selector over a valid/ready handshake. It produces the extended immediate one cycle later, buffered in a 2-entry skid buffer so that back-pressure from execute never costs throughput. It extends the monocycle immediate generator in four ways: XLEN-wide sign extension, two additional formats (CSR zimm, shift amount), an illegal-selector flag, and flush support.

## Interface
- XLEN, default 32, datapath width of `imm_ext`; legal values are 32 and 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards every buffered entry and the current input beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- inst  in  32  instruction word (bits 6:0 are ignored)
- imm_src  in  3  immediate-type selector
- out_valid  out  1  `imm_ext` / `imm_err` valid
- out_ready  in  1  downstream accepts
- imm_ext  out  XLEN  extended immediate
- imm_err  out  1  `imm_src` was 3'b111 for this beat

## Operation
- Selector encoding; `s` is `inst[31]`, and every result is sign-extended to XLEN unless stated otherwise:
  - 000 I: `inst[31:20]`
  - 001 S: `{inst[31:25], inst[11:7]}`
  - 101 B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`
  - 010 U: `{inst[31:12], 12'b0}`, sign-extended from bit 31
  - 110 J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`
  - 011 Z: `inst[19:15]`, zero-extended
  - 100 SH: zero-extended; `inst[25:20]` when XLEN=64, `inst[24:20]` when XLEN=32
  - 111: `imm_ext` = 0 and `imm_err` = 1
- A beat is accepted when `in_valid && in_ready`; it is delivered when `out_valid && out_ready`.
- The buffer holds 0, 1 or 2 entries in FIFO order. State is EMPTY / ONE / TWO:
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without deliver.
  - ONE -> EMPTY on deliver without accept.
  - ONE -> ONE on simultaneous accept and deliver.
  - TWO -> ONE on deliver. No accept is possible in TWO.
- `in_ready` = (state != TWO). It is registered and must not depend combinationally on `out_ready`.
- `out_valid` = (state != EMPTY). `imm_ext` and `imm_err` always come from the head entry, which is a register.
- Flush has priority over both accept and deliver. On a flush cycle the buffer returns to EMPTY at the next edge, the input beat is dropped, and no entry is delivered.
- Reset values: state EMPTY, `out_valid` 0, `in_ready` 1, `imm_ext` 0, `imm_err` 0.
- Payload registers of an empty slot hold their last value. Only `out_valid` qualifies them.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on the outputs after edge N and deliverable in cycle N+1.
- Throughput is 1 beat/cycle whenever `out_ready` is held high.
- When `out_ready` is deasserted, the buffer absorbs at most 2 beats and `in_ready` falls in the cycle after the buffer reaches TWO. No beat is lost or duplicated.
- Head output is stable while `out_valid && !out_ready`.
- An asserted `rst_n` forces reset values immediately, including mid-transfer; in-flight entries are lost.
- Flush and reset are both legal in any state, including TWO with `out_ready` = 0.

## Structure
- Package `imm_pkg` holds:
  - the `imm_src_e` enum with the eight encodings above;
  - the constant `IMM_SRC_W = 3`;
  - a packed struct `imm_entry_t` with fields `{imm, err}`, sized by XLEN through a parameterised typedef or localparam in the user.
- Sub-module `imm_decode` (combinational) implements `inst`, `imm_src` -> `imm_ext`, `imm_err` for a given XLEN. The top level instantiates it once on the input side and registers its result into the skid buffer.
- Target size is roughly 150-250 lines of RTL in total.

## Test plan
- Formats, XLEN=32 and 64, `out_ready` = 1: `inst` = 0xFFF00093 with I gives 0xFFFFFFFF / 0xFFFFFFFFFFFFFFFF one cycle later; `inst` = 0x800000EF with J gives 0xFFF00000 (sign-extended); U on 0x12345037 gives 0x12345000.
- New types: Z on `inst[19:15]` = 0x1F gives 0x1F; SH with `inst[25:20]` = 0x3F gives 0x3F for XLEN=64 and 0x1F for XLEN=32; selector 111 gives `imm_ext` = 0 and `imm_err` = 1.
- Back-pressure: stream 5 beats with `out_ready` = 0 for 4 cycles. `in_ready` drops after 2 accepts; on release all 5 beats arrive in order with no duplicates, and the head stays stable while stalled.
- Streaming at full rate: 100 random beats with `out_ready` = 1 give 100 deliveries in 101 cycles, and the scoreboard matches the decode model.
- Flush: in state TWO, assert `flush` together with `in_valid` = 1. The next cycle shows `out_valid` = 0 and `in_ready` = 1, and the dropped beat never appears.
- Reset mid-operation: pull `rst_n` low while in ONE with `out_ready` = 0. Outputs go to reset values without waiting for a clock edge; after release the first new beat is delivered correctly.
